// File: rtl/div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_seq_ctrl
//   Iterative divide sequencer for the RV32M DIV/DIVU/REM/REMU operations in
//   the execute stage. One operation is accepted per start pulse. A restoring
//   shift-subtract datapath runs under a small FSM. busy stays high while the
//   unit works so the pipeline can stall on it. Divide-by-zero and signed
//   overflow finish early with the results the RISC-V ISA defines.
//
//   Optional feature, controlled by the macro DIV_RESULT_CACHE_EN:
//     The unit remembers the operands, the signedness, the quotient and the
//     remainder of the last normal completion. A later op with the same
//     operands and signedness returns in one cycle. This applies to both the
//     div and rem variants. Reset and flushed ops invalidate the entry.
//     Without the macro there is no cache, and every non-special op takes
//     the full latency.
//
// Parameters
//   XLEN             operand/result width
//   STEPS_PER_CYCLE  quotient bits resolved per ITER cycle (1, 2 or 4)
//
// Ports
//   clk     in   1     rising-edge clock
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     request pulse, honoured only when busy=0
//   op      in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//   rs1     in   XLEN  dividend (sampled with start)
//   rs2     in   XLEN  divisor (sampled with start)
//   flush   in   1     abort the current op; wins over start
//   busy    out  1     high whenever the FSM is not idle
//   done    out  1     one-cycle completion pulse, result valid with it
//   result  out  XLEN  quotient or remainder, held until the next done
// ---------------------------------------------------------------------------
module div_seq_ctrl #(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam int ITERS = XLEN / STEPS_PER_CYCLE;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 || STEPS_PER_CYCLE == 4)) begin : g_bad_steps
        $error("div_seq_ctrl: STEPS_PER_CYCLE must be 1, 2 or 4");
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]      state;
    logic            op_rem_q;     // selected output is the remainder
    logic            neg_quo_q;    // quotient needs negation in FIX
    logic            neg_rem_q;    // remainder needs negation in FIX
    logic [XLEN:0]   acc_q;        // partial remainder, one extra bit for the borrow
    logic [XLEN-1:0] dvd_q;        // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] dsr_q;        // divisor magnitude
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] pend_q;       // value shown during the DONE cycle
    logic [XLEN-1:0] result_q;     // value held between completions

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    logic            op_uns;
    logic            op_rem;
    logic            sign_a;
    logic            sign_b;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    assign op_uns   = op[0];
    assign op_rem   = op[1];
    assign sign_a   = !op_uns && rs1[XLEN-1];
    assign sign_b   = !op_uns && rs2[XLEN-1];
    assign div_zero = (rs2 == '0);
    assign overflow = !op_uns && (rs1 == MIN_NEG) && (rs2 == '1);
    assign special  = div_zero || overflow;
    assign abs_a    = sign_a ? -rs1 : rs1;
    assign abs_b    = sign_b ? -rs2 : rs2;

    // Divide by zero: quotient is all ones and the remainder is the dividend.
    // Overflow: the quotient is the dividend itself and the remainder is zero.
    assign special_res = div_zero ? (op_rem ? rs1 : '1)
                                  : (op_rem ? '0  : rs1);

`ifdef DIV_RESULT_CACHE_EN
    logic            cache_valid;
    logic [XLEN-1:0] cache_a;
    logic [XLEN-1:0] cache_b;
    logic            cache_signed;
    logic [XLEN-1:0] cache_quo;
    logic [XLEN-1:0] cache_rem;
    logic            fill_q;       // current op is a normal op that will refill the cache
    logic            cache_hit;

    assign cache_hit = cache_valid && (cache_a == rs1) && (cache_b == rs2) &&
                       (cache_signed == !op_uns);
`endif

    // ------------------------------------------------------------------
    // Restoring divide steps for one ITER cycle
    // ------------------------------------------------------------------
    logic [XLEN:0]   acc_nxt;
    logic [XLEN-1:0] dvd_nxt;

    always_comb begin : iter_step
        logic [XLEN:0]   a;
        logic [XLEN:0]   t;
        logic [XLEN-1:0] d;
        // NOTE: a default is assigned to every variable before the loop so no
        // path leaves it unassigned; otherwise synthesis would infer a latch.
        // Blocking '=' is correct here, because each step must see the value
        // that the step before it produced.
        a = acc_q;
        d = dvd_q;
        t = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            a = {a[XLEN-1:0], d[XLEN-1]};
            t = a - {1'b0, dsr_q};
            if (!t[XLEN]) begin
                a = t;
                d = {d[XLEN-2:0], 1'b1};
            end else begin
                d = {d[XLEN-2:0], 1'b0};
            end
        end
        acc_nxt = a;
        dvd_nxt = d;
    end

    // Sign correction applied in FIX.
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
    assign rem_fix = neg_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy   = (state != S_IDLE);
    // A flush that arrives in the DONE cycle suppresses the pulse. In that
    // case the held result is not replaced.
    assign done   = (state == S_DONE) && !flush;
    assign result = done ? pend_q : result_q;

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    // NOTE: every register is cleared on reset, including the cache entry,
    // so that a fresh unit never matches stale operands. Sequential state
    // uses non-blocking '<=' throughout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            result_q  <= '0;
`ifdef DIV_RESULT_CACHE_EN
            cache_valid  <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_signed <= 1'b0;
            cache_quo    <= '0;
            cache_rem    <= '0;
            fill_q       <= 1'b0;
`endif
        end else if (flush) begin
            state <= S_IDLE;
`ifdef DIV_RESULT_CACHE_EN
            fill_q <= 1'b0;
            if (state != S_IDLE) begin
                cache_valid <= 1'b0;
            end
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_rem_q <= op_rem;
                        if (special) begin
                            pend_q <= special_res;
                            state  <= S_DONE;
                        end
`ifdef DIV_RESULT_CACHE_EN
                        else if (cache_hit) begin
                            pend_q <= op_rem ? cache_rem : cache_quo;
                            state  <= S_DONE;
                        end
`endif
                        else begin
                            neg_quo_q <= sign_a ^ sign_b;
                            neg_rem_q <= sign_a;
                            acc_q     <= '0;
                            dvd_q     <= abs_a;
                            dsr_q     <= abs_b;
                            cnt_q     <= CNT_INIT;
                            state     <= S_ITER;
`ifdef DIV_RESULT_CACHE_EN
                            // The entry is rewritten for this op. It stays
                            // invalid until the op completes without a flush.
                            cache_valid  <= 1'b0;
                            cache_a      <= rs1;
                            cache_b      <= rs2;
                            cache_signed <= !op_uns;
                            fill_q       <= 1'b1;
`endif
                        end
                    end
                end

                S_ITER: begin
                    acc_q <= acc_nxt;
                    dvd_q <= dvd_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    pend_q <= op_rem_q ? rem_fix : quo_fix;
`ifdef DIV_RESULT_CACHE_EN
                    cache_quo <= quo_fix;
                    cache_rem <= rem_fix;
`endif
                    state <= S_DONE;
                end

                S_DONE: begin
                    result_q <= pend_q;
`ifdef DIV_RESULT_CACHE_EN
                    if (fill_q) begin
                        cache_valid <= 1'b1;
                    end
                    fill_q <= 1'b0;
`endif
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_seq_ctrl
//   Self-checking bench for div_seq_ctrl with XLEN=32 and STEPS_PER_CYCLE=1.
//   It runs a table of directed vectors, a few hand-written multi-cycle
//   sequences (flush, reset, ignored starts) and randomized ops. All of them
//   are checked against an arithmetic reference model. The model follows
//   DIV_RESULT_CACHE_EN when the macro is defined for the build.
// ---------------------------------------------------------------------------
module tb_div_seq_ctrl;

    localparam int FULL_LAT = 34;
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
    localparam int HIT_LAT  = 1;
`else
    localparam bit CACHE_ON = 1'b0;
    localparam int HIT_LAT  = FULL_LAT;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: plain arithmetic plus a one-entry result memory
    // ------------------------------------------------------------------
    bit          m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    bit          m_signed;
    logic [31:0] last_result;

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0]) return o[1] ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
        sa = int'(a);
        sb = int'(b);
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    task automatic model_step(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] exp_res, output int exp_lat);
        bit sp;
        exp_res = ref_result(o, a, b);
        sp = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (sp) begin
            exp_lat = 1;
        end else if (CACHE_ON && m_valid && m_a == a && m_b == b && m_signed == !o[0]) begin
            exp_lat = 1;
        end else begin
            exp_lat  = FULL_LAT;
            m_valid  = 1'b1;
            m_a      = a;
            m_b      = b;
            m_signed = !o[0];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // The task is entered 1 time unit after a rising edge with the unit idle.
    // poke > 0 pulses an illegal start on that cycle after the accept. poke_done
    // pulses start in the DONE cycle. Returns the observed result and the
    // latency, counted in edges from the accept edge, which is edge 1.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input bit poke_done, input string tag,
                          output logic [31:0] res, output int lat);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            if (lat == poke) begin
                start = 1'b1;
                op    = 2'b00;
                rs1   = 32'd5;
                rs2   = 32'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        res = done ? result : 32'hDEAD_BEEF;
        if (poke_done) begin
            start = 1'b1;
            op    = 2'b01;
            rs1   = 32'd9;
            rs2   = 32'd3;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        if (res !== 32'hDEAD_BEEF) last_result = res;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [31:0] res;
        logic [31:0] exp_res;
        int          lat;
        int          exp_lat;
        int          done_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;

        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         FULL_LAT};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          HIT_LAT};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  FULL_LAT};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  HIT_LAT};
        vecs[4]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[5]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1};
        vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[8]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          FULL_LAT};
        vecs[9]  = '{2'b00, 32'd100,        32'd7,          32'd14,         FULL_LAT};
        vecs[10] = '{2'b10, 32'd100,        32'd7,          32'd2,          HIT_LAT};
        vecs[11] = '{2'b01, 32'd100,        32'd7,          32'd14,         FULL_LAT};
        vecs[12] = '{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  FULL_LAT};
        vecs[13] = '{2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          FULL_LAT};
        vecs[14] = '{2'b11, 32'hFFFF_FFFF,  32'd1,          32'd0,          FULL_LAT};
        vecs[15] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  HIT_LAT};
        vecs[16] = '{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  FULL_LAT};
        vecs[17] = '{2'b01, 32'd7,          32'd100,        32'd0,          FULL_LAT};

        m_valid     = 1'b0;
        m_a         = '0;
        m_b         = '0;
        m_signed    = 1'b0;
        last_result = '0;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, busy}, 32'd0);
        check("reset_done",   {31'd0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 18; i++) begin
            model_step(vecs[i].op, vecs[i].a, vecs[i].b, exp_res, exp_lat);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, $sformatf("vec%0d", i), res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // ---------------- start while busy / in DONE is ignored ----------------
        model_step(2'b01, 32'd1000, 32'd7, exp_res, exp_lat);
        run_op(2'b01, 32'd1000, 32'd7, 5, 1'b1, "poke", res, lat);
        check("poke_result",  res,     32'd142);
        check("poke_latency", 32'(lat), 32'(FULL_LAT));
        check("poke_done_low", {31'd0, done}, 32'd0);

        // ---------------- flush on the 10th ITER cycle ----------------
        start = 1'b1; op = 2'b01; rs1 = 32'd200; rs2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush   = 1'b0;
        m_valid = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_result_held", result, last_result);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("flush_no_done", 32'(done_seen), 32'd0);
        model_step(2'b01, 32'd9, 32'd3, exp_res, exp_lat);
        run_op(2'b01, 32'd9, 32'd3, 0, 1'b0, "after_flush", res, lat);
        check("after_flush_result",  res,      32'd3);
        check("after_flush_latency", 32'(lat), 32'(FULL_LAT));

        // ---------------- flush together with start in IDLE ----------------
        start = 1'b1; flush = 1'b1; op = 2'b01; rs1 = 32'd50; rs2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        // ---------------- a flushed op invalidates the remembered result ----------------
        model_step(2'b01, 32'd100, 32'd7, exp_res, exp_lat);
        run_op(2'b01, 32'd100, 32'd7, 0, 1'b0, "fill", res, lat);
        check("fill_result", res, exp_res);
        start = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b1;
        #1;
        check("flush_hit_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        flush   = 1'b0;
        m_valid = 1'b0;
        check("flush_hit_busy",   {31'd0, busy}, 32'd0);
        check("flush_hit_result", result,        32'd14);
        model_step(2'b11, 32'd100, 32'd7, exp_res, exp_lat);
        run_op(2'b11, 32'd100, 32'd7, 0, 1'b0, "after_inval", res, lat);
        check("after_inval_result",  res,      32'd2);
        check("after_inval_latency", 32'(lat), 32'(FULL_LAT));

        // ---------------- asynchronous reset mid-ITER ----------------
        start = 1'b1; op = 2'b00; rs1 = 32'd12345; rs2 = 32'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy",   {31'd0, busy}, 32'd0);
        check("rst_mid_done",   {31'd0, done}, 32'd0);
        check("rst_mid_result", result,        32'd0);
        m_valid     = 1'b0;
        last_result = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("rst_no_done", 32'(done_seen), 32'd0);

        // ---------------- randomized ops against the model ----------------
        ra = 32'd100;
        rb = 32'd7;
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            ro  = 2'($urandom_range(0, 3));
            if (sel < 2) begin
                // Reuse the previous operands to hit the remembered-result path.
            end else if (sel == 2) begin
                ra = $urandom;
                rb = 32'd0;
            end else if (sel == 3) begin
                ra = $urandom;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 4) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 5) begin
                ra = $urandom;
                rb = 32'($urandom_range(1, 15));
            end else begin
                ra = $urandom;
                rb = $urandom >> $urandom_range(0, 31);
            end
            model_step(ro, ra, rb, exp_res, exp_lat);
            run_op(ro, ra, rb, 0, 1'b0, $sformatf("rnd%0d", i), res, lat);
            check($sformatf("rnd%0d_result op=%0d a=%h b=%h", i, ro, ra, rb), res, exp_res);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
